// File: rtl/pacman_movement_controller.sv
// pacman_movement_controller
//   Turns player key presses and the slow game tick into Pac-Man tile moves.
//   Once per tick it tries the buffered requested direction first, then the
//   current heading. Each candidate tile is checked against the map through
//   the map controller read port. A legal move is committed to the character
//   registers with a one-cycle write strobe.
//
// Ports
//   clock_50        in   system clock
//   resetn          in   synchronous active-low reset
//   tick            in   one-cycle game-step pulse
//   pacman_controls in   raw KEYs, active-low: [0]=right [1]=down [2]=up [3]=left
//   map_x/map_y     out  map read address (tile coordinates)
//   sprite_data_out in   map read data, valid READ_LATENCY cycles after address
//   x_in/y_in       out  pixel position of the registered tile
//   character_type  out  register select, constant PACMAN_TYPE
//   readwrite       out  one-cycle write strobe to the character registers
//   heading         out  current direction: 0=right 1=down 2=up 3=left
//   busy            out  high whenever the FSM is not in IDLE
//   overrun         out  sticky: a tick arrived while busy
module pacman_movement_controller #(
    parameter int          MAP_W        = 32,
    parameter int          MAP_H        = 24,
    parameter int          TILE_PX      = 5,
    parameter logic [2:0]  WALL_CODE    = 3'd1,
    parameter logic [2:0]  PACMAN_TYPE  = 3'd0,
    parameter int          START_X      = 1,
    parameter int          START_Y      = 1,
    parameter int          READ_LATENCY = 1
) (
    input  logic       clock_50,
    input  logic       resetn,
    input  logic       tick,
    input  logic [3:0] pacman_controls,
    output logic [4:0] map_x,
    output logic [4:0] map_y,
    input  logic [2:0] sprite_data_out,
    output logic [7:0] x_in,
    output logic [7:0] y_in,
    output logic [2:0] character_type,
    output logic       readwrite,
    output logic [1:0] heading,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [2:0] {
        WRITE_INIT, IDLE, TRY_REQ, WAIT_REQ, TRY_HEAD, WAIT_HEAD, WRITE, DONE
    } state_t;

    localparam logic [4:0] X_MAX   = 5'(MAP_W - 1);
    localparam logic [4:0] Y_MAX   = 5'(MAP_H - 1);
    localparam logic [4:0] X_START = 5'(START_X);
    localparam logic [4:0] Y_START = 5'(START_Y);
    localparam logic [7:0] TPX     = 8'(TILE_PX);
    localparam logic [1:0] RL      = 2'(READ_LATENCY);

    state_t     state;
    logic [4:0] tile_x, tile_y;
    logic [1:0] pending_dir, req_dir;
    logic       pending_valid;
    logic [1:0] lat_cnt;

    logic [3:0] key_act;
    logic       key_any;
    logic [1:0] key_dir;

    assign key_act = ~pacman_controls;
    assign key_any = |key_act;

    // Priority right > down > up > left.
    always_comb begin
        key_dir = 2'd3;
        if      (key_act[0]) key_dir = 2'd0;
        else if (key_act[1]) key_dir = 2'd1;
        else if (key_act[2]) key_dir = 2'd2;
    end

    // Neighbour tile in the given direction with toroidal wrap, packed {x,y}.
    function automatic logic [9:0] step(input logic [1:0] dir,
                                        input logic [4:0] x,
                                        input logic [4:0] y);
        logic [4:0] nx, ny;
        nx = x;
        ny = y;
        case (dir)
            2'd0: nx = (x == X_MAX) ? 5'd0  : x + 5'd1;
            2'd1: ny = (y == Y_MAX) ? 5'd0  : y + 5'd1;
            2'd2: ny = (y == 5'd0)  ? Y_MAX : y - 5'd1;
            default: nx = (x == 5'd0) ? X_MAX : x - 5'd1;
        endcase
        return {nx, ny};
    endfunction

    assign x_in           = {3'b000, tile_x} * TPX;
    assign y_in           = {3'b000, tile_y} * TPX;
    assign character_type = PACMAN_TYPE;
    assign busy           = (state != IDLE);

    always_ff @(posedge clock_50) begin
        if (!resetn) begin
            state         <= WRITE_INIT;
            tile_x        <= X_START;
            tile_y        <= Y_START;
            heading       <= 2'd0;
            pending_dir   <= 2'd0;
            pending_valid <= 1'b0;
            req_dir       <= 2'd0;
            lat_cnt       <= 2'd0;
            map_x         <= 5'd0;
            map_y         <= 5'd0;
            readwrite     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            readwrite <= 1'b0;

            // Newest press always wins; no press keeps the old request.
            if (key_any) begin
                pending_dir   <= key_dir;
                pending_valid <= 1'b1;
            end

            if (tick && state != IDLE)
                overrun <= 1'b1;

            case (state)
                // Publish the start tile once without waiting for a tick;
                // the strobe is shared with the normal WRITE state.
                WRITE_INIT: begin
                    readwrite <= 1'b1;
                    state     <= WRITE;
                end
                // A press landing with the tick counts for this tick.
                IDLE: if (tick)
                    state <= (pending_valid || key_any) ? TRY_REQ : TRY_HEAD;
                TRY_REQ: begin
                    {map_x, map_y} <= step(pending_dir, tile_x, tile_y);
                    req_dir        <= pending_dir;
                    lat_cnt        <= 2'd0;
                    state          <= WAIT_REQ;
                end
                // map_x/map_y hold the candidate, so a legal move copies them.
                WAIT_REQ: begin
                    if (lat_cnt == RL) begin
                        if (sprite_data_out != WALL_CODE) begin
                            heading   <= req_dir;
                            tile_x    <= map_x;
                            tile_y    <= map_y;
                            if (!key_any) pending_valid <= 1'b0;
                            readwrite <= 1'b1;
                            state     <= WRITE;
                        end else begin
                            // Request kept so the turn is retried next tick.
                            state <= TRY_HEAD;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                TRY_HEAD: begin
                    {map_x, map_y} <= step(heading, tile_x, tile_y);
                    lat_cnt        <= 2'd0;
                    state          <= WAIT_HEAD;
                end
                WAIT_HEAD: begin
                    if (lat_cnt == RL) begin
                        if (sprite_data_out != WALL_CODE) begin
                            tile_x    <= map_x;
                            tile_y    <= map_y;
                            readwrite <= 1'b1;
                            state     <= WRITE;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                WRITE:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pacman_movement_controller.sv
// Directed bench for pacman_movement_controller: a behavioural map with a
// one-cycle read latency, a write monitor, and hand-computed expectations.
module tb_pacman_movement_controller;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] keys = 4'hF;
    logic [4:0] map_x, map_y;
    logic [2:0] sprite = 3'd0;
    logic [7:0] x_in, y_in;
    logic [2:0] character_type;
    logic       readwrite;
    logic [1:0] heading;
    logic       busy, overrun;

    pacman_movement_controller dut (
        .clock_50(clk), .resetn(resetn), .tick(tick), .pacman_controls(keys),
        .map_x(map_x), .map_y(map_y), .sprite_data_out(sprite),
        .x_in(x_in), .y_in(y_in), .character_type(character_type),
        .readwrite(readwrite), .heading(heading), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    logic [2:0] map_mem [0:31][0:31];
    always @(posedge clk) sprite <= map_mem[map_y][map_x];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor
    int wr_cnt = 0, wr_x = 0, wr_y = 0, wr_cyc = 0, wr_type = 0;
    always @(negedge clk) begin
        if (readwrite) begin
            wr_cnt  = wr_cnt + 1;
            wr_x    = int'(x_in);
            wr_y    = int'(y_in);
            wr_cyc  = cyc;
            wr_type = int'(character_type);
        end
    end

    int n_chk = 0, n_err = 0, t_cyc = 0, base = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic pulse_tick();
        @(negedge clk); tick = 1'b1; t_cyc = cyc;
        @(negedge clk); tick = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk); keys = k;
        @(negedge clk); keys = 4'hF;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin @(negedge clk); n++; end
        chk(tag, busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk); resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rw", readwrite, 0);
        chk("rst_ovr", overrun, 0);
        resetn = 1'b1;
    endtask

    // One tick with no walls expected to block; checks the move and latency.
    task automatic move(input string tag, input int ex, input int ey, input int lat);
        base = wr_cnt;
        pulse_tick();
        wait_idle({tag, "_idle"});
        chk({tag, "_cnt"}, wr_cnt, base + 1);
        chk({tag, "_x"}, wr_x, ex);
        chk({tag, "_y"}, wr_y, ey);
        if (lat > 0) chk({tag, "_lat"}, wr_cyc - t_cyc, lat);
    endtask

    initial begin
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++)
                map_mem[y][x] = 3'd0;

        // Reset state and start-position write
        repeat (3) @(negedge clk);
        chk("rst_map_x", map_x, 0);
        chk("rst_map_y", map_y, 0);
        chk("rst_rw0", readwrite, 0);
        resetn = 1'b1;
        wait_idle("init_idle");
        chk("init_cnt", wr_cnt, 1);
        chk("init_x", wr_x, 5);
        chk("init_y", wr_y, 5);
        chk("init_type", wr_type, 0);
        chk("init_head", heading, 0);
        chk("init_ovr", overrun, 0);

        // Open map, default heading right
        move("r1", 10, 5, 4);
        move("r2", 15, 5, 4);
        move("r3", 20, 5, 4);

        // Blocked turn falls back to heading, then the buffered turn succeeds
        do_reset();
        wait_idle("rst2_idle");
        move("to21", 10, 5, 4);
        map_mem[2][2] = 3'd1;
        press(4'b1101);
        move("fb", 15, 5, 7);
        chk("fb_head", heading, 0);
        map_mem[2][2] = 3'd0;
        move("turn", 15, 10, 4);
        chk("turn_head", heading, 1);
        move("pclr", 15, 15, 4);          // pending cleared: continues down

        // Walk to (0,5) heading left, then wrap
        move("d4", 15, 20, 4);
        move("d5", 15, 25, 4);
        press(4'b0111);
        move("l2", 10, 25, 4);
        chk("l_head", heading, 3);
        move("l1", 5, 25, 0);
        move("l0", 0, 25, 0);
        move("lwrap", 155, 25, 4);

        // Up wrap from (31,0)
        press(4'b1011);
        for (int i = 4; i >= 0; i--) move("up", 155, i * 5, 0);
        move("uwrap", 155, 115, 4);
        chk("u_head", heading, 2);

        // Right wrap and down wrap
        press(4'b1110);
        move("rwrap", 0, 115, 4);
        press(4'b1101);
        move("dwrap", 0, 0, 4);
        chk("dw_head", heading, 1);

        // Both candidates walled: no write, position unchanged
        map_mem[0][1] = 3'd1;
        map_mem[1][0] = 3'd1;
        press(4'b1110);
        base = wr_cnt;
        pulse_tick();
        wait_idle("blk_idle");
        chk("blk_cnt", wr_cnt, base);
        chk("blk_x", x_in, 0);
        chk("blk_y", y_in, 0);
        chk("blk_head", heading, 1);
        chk("blk_mapy", map_y, 1);
        map_mem[0][1] = 3'd0;
        map_mem[1][0] = 3'd0;

        // Tick while busy: dropped, overrun sticky; pending right still taken
        base = wr_cnt;
        pulse_tick();
        pulse_tick();
        wait_idle("ovr_idle");
        repeat (3) @(negedge clk);
        chk("ovr_flag", overrun, 1);
        chk("ovr_cnt", wr_cnt, base + 1);
        chk("ovr_x", x_in, 5);

        // Reset clears overrun and re-publishes start
        base = wr_cnt;
        do_reset();
        wait_idle("rst3_idle");
        chk("rst3_cnt", wr_cnt, base + 1);
        chk("rst3_ovr", overrun, 0);

        // Reset during WAIT_REQ aborts the move
        press(4'b1101);
        pulse_tick();
        @(negedge clk);                   // now in WAIT_REQ
        chk("abort_busy", busy, 1);
        base = wr_cnt;
        resetn = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_nowr", wr_cnt, base);
        resetn = 1'b1;
        wait_idle("abort_idle");
        chk("abort_cnt", wr_cnt, base + 1);
        chk("abort_x", wr_x, 5);
        chk("abort_y", wr_y, 5);
        chk("abort_head", heading, 0);

        // Press in the same cycle as the tick takes effect on that tick
        base = wr_cnt;
        @(negedge clk); keys = 4'b1101; tick = 1'b1; t_cyc = cyc;
        @(negedge clk); keys = 4'hF; tick = 1'b0;
        wait_idle("same_idle");
        chk("same_cnt", wr_cnt, base + 1);
        chk("same_y", wr_y, 10);
        chk("same_x", wr_x, 5);
        chk("same_lat", wr_cyc - t_cyc, 4);
        chk("same_head", heading, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pacman_movement_controller.md
Name: pacman_movement_controller

Overview:
- Upstream stage of the character display path: turns player button presses and the slow game tick into Pac-Man tile moves.
- Checks each candidate tile against the map through the map controller read port.
- Commits the new position into the character registers, which the character display controller then draws.
- One move is evaluated per game tick, using a two-attempt rule: try the buffered requested direction first, then the current heading.

Parameters:
- MAP_W, 32, map width in tiles (x wraps modulo MAP_W).
- MAP_H, 24, map height in tiles (y wraps modulo MAP_H).
- TILE_PX, 5, pixels per tile edge; pixel coordinate = tile * TILE_PX.
- WALL_CODE, 3'd1, sprite code that blocks movement.
- PACMAN_TYPE, 3'd0, character_type driven on writes.
- START_X, 1, reset tile x.
- START_Y, 1, reset tile y.
- READ_LATENCY, 1, cycles from map_x/map_y valid to sprite_data_out valid (1..3).

Ports:
- clock_50  in  1  system clock, 50 MHz.
- resetn  in  1  synchronous active-low reset.
- tick  in  1  one-cycle game-step pulse, from the rate divider edge.
- pacman_controls  in  4  raw KEYs, active-low: [0]=right, [1]=down, [2]=up, [3]=left.
- map_x  out  5  map read tile x.
- map_y  out  5  map read tile y.
- sprite_data_out  in  3  map read data.
- x_in  out  8  pixel x to character registers.
- y_in  out  8  pixel y to character registers.
- character_type  out  3  register select, always PACMAN_TYPE.
- readwrite  out  1  1 = write strobe to character registers, one cycle wide.
- heading  out  2  current direction: 0=right, 1=down, 2=up, 3=left.
- busy  out  1  high while not in IDLE.
- overrun  out  1  sticky; set when tick arrives while busy.

Behaviour:
- Reset is synchronous and active-low. On resetn=0 at a clock_50 edge:
  - tile=(START_X,START_Y), heading=0, pending_valid=0, state=WRITE_INIT.
  - map_x=map_y=0, readwrite=0, overrun=0.
  - Outputs are registered. x_in/y_in always reflect the registered tile * TILE_PX.
  - Reset mid-operation aborts any move; no partial write occurs.
- WRITE_INIT (first cycle after reset release): readwrite=1 with the start position, then IDLE. This lets the display see the start position without waiting for a tick.
- Button buffering runs every cycle, independent of state.
  - Any active (low) key loads pending_dir; priority is right > down > up > left.
  - Sets pending_valid=1. A newer press overwrites the older one.
  - No key pressed leaves the pending request unchanged.
- FSM states:
  - IDLE: on tick → TRY_REQ if pending_valid, else TRY_HEAD.
  - TRY_REQ: compute the neighbour in pending_dir; drive map_x/map_y → WAIT_REQ.
  - WAIT_REQ: count READ_LATENCY cycles, then sample sprite_data_out.
    - Not WALL_CODE → heading=pending_dir, pending_valid=0, tile=neighbour → WRITE.
    - WALL_CODE → TRY_HEAD. pending_valid is kept, so the turn is retried next tick (pre-turn buffering).
  - TRY_HEAD: compute the neighbour in heading; drive map_x/map_y → WAIT_HEAD.
  - WAIT_HEAD: after READ_LATENCY cycles, sample sprite_data_out.
    - Not wall → tile=neighbour → WRITE.
    - Wall → DONE; position is unchanged and no write is issued.
  - WRITE: readwrite=1 for exactly one cycle, x_in/y_in = new pixel position → DONE.
  - DONE: one cycle → IDLE.
- Neighbour arithmetic:
  - Right: x+1, and MAP_W-1 wraps to 0. Left: 0 wraps to MAP_W-1.
  - Down: y+1, and MAP_H-1 wraps to 0. Up: 0 wraps to MAP_H-1.
  - Pixel multiply is unsigned. With defaults the maxima are 155 and 115, which fit 8 bits.
- Latency: tick → readwrite.
  - 3+READ_LATENCY cycles (direct move).
  - 5+2·READ_LATENCY cycles (fallback move).
- Simultaneous events:
  - tick while busy: the tick is dropped and overrun is set. It clears only on reset.
  - tick in the same cycle as a new key press: the press is buffered first and takes effect on this tick.
  - A key held across many ticks moves one tile per tick.
- busy=1 in every state except IDLE.
- readwrite is never asserted outside WRITE/WRITE_INIT.

Test Plan:
- Reset release, START=(1,1) → one readwrite pulse with x_in=5, y_in=5, character_type=0. Then idle; heading=0, overrun=0.
- Open map, no keys, 3 ticks → moves right each tick: x_in=10, 15, 20, y_in=5. Each pulse arrives 4 cycles after tick (READ_LATENCY=1).
- Press KEY[1] (down) with a wall at (2,2) while at (2,1); tick → requested direction blocked, falls back to right: tile (3,1), heading stays 0. Remove the wall-adjacent condition at the next tile; next tick → moves down to (3,2), heading=1, pending cleared.
- Heading left at (0,5) on an open row, tick → x wraps to 31: x_in=155, y_in=25. Heading up at (4,0) → y=23, y_in=115.
- Walls on both the requested and heading tiles, tick → no readwrite, position unchanged, busy returns low after DONE.
- tick pulses 2 cycles apart → second tick ignored, overrun=1. Assert resetn=0 during WAIT_REQ → no write from the aborted move, state restarts with WRITE_INIT.
